// File: rtl/conv1_window_feeder_pkg.sv
// Shared CNN package: default geometry of the ECG front end and the sample and
// window types used by the window feeder and by the conv layer's input port.
package conv1_window_feeder_pkg;

    localparam int DEF_DW      = 8;
    localparam int DEF_K       = 5;
    localparam int DEF_SEG_LEN = 187;

    typedef logic signed [DEF_DW-1:0] sample_t;
    typedef sample_t [DEF_K-1:0]      window_t;

endpackage

// File: rtl/conv1_window_feeder_if.sv
// Sample-in / window-out handshake bundle for the conv1 window feeder.
// The master modport is the feeder itself; the slave modport is its
// surroundings (sample source and conv-layer consumer).
interface conv1_window_feeder_if #(
    parameter int DW      = conv1_window_feeder_pkg::DEF_DW,
    parameter int K       = conv1_window_feeder_pkg::DEF_K,
    parameter int SEG_LEN = conv1_window_feeder_pkg::DEF_SEG_LEN
);
    import conv1_window_feeder_pkg::*;

    localparam int IDX_W = $clog2(SEG_LEN - K + 1);

    logic                   s_valid;
    logic                   s_ready;
    logic signed [DW-1:0]   s_data;
    logic                   flush;
    logic                   m_valid;
    logic                   m_ready;
    logic [K-1:0][DW-1:0]   m_win;
    logic [IDX_W-1:0]       m_idx;
    logic                   m_last;

    modport master (
        input  s_valid, s_data, flush, m_ready,
        output s_ready, m_valid, m_win, m_idx, m_last
    );

    modport slave (
        output s_valid, s_data, flush, m_ready,
        input  s_ready, m_valid, m_win, m_idx, m_last
    );

endinterface

// File: rtl/conv1_window_feeder.sv
// Sliding-window front end for the first conv stage: shifts accepted ECG
// samples into a K-deep register and presents a stride-1 window for every
// sample from the K-th of each beat segment onward. Windows never straddle
// a segment boundary because the counter restarts in FILL after each segment.
module conv1_window_feeder #(
    parameter int DW      = conv1_window_feeder_pkg::DEF_DW,
    parameter int K       = conv1_window_feeder_pkg::DEF_K,
    parameter int SEG_LEN = conv1_window_feeder_pkg::DEF_SEG_LEN
) (
    input logic                   clk,
    input logic                   rst,
    conv1_window_feeder_if.master bus
);
    import conv1_window_feeder_pkg::*;

    localparam int CNT_W = $clog2(SEG_LEN);
    localparam int IDX_W = $clog2(SEG_LEN - K + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SEG_LEN - 1);
    localparam logic [CNT_W-1:0] FIRST_WIN = CNT_W'(K - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [K-1:0][DW-1:0] win_q, win_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 s_ready;
    logic                 accept;

    // A pending window blocks new samples unless it is consumed this cycle; flush blocks everything.
    always_comb begin
        s_ready = !bus.flush && (!valid_q || bus.m_ready);
        accept  = bus.s_valid && s_ready;
    end

    // Next-state logic: flush wins, then an accepted sample, then a bare consume.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (bus.flush) begin
            state_d = FILL;
            cnt_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (accept) begin
            win_d = {bus.s_data, win_q[K-1:1]};
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
            if (state_q == RUN) begin
                valid_d = 1'b1;
                idx_d   = IDX_W'(cnt_q - FIRST_WIN);
                last_d  = (cnt_q == LAST_CNT);
            end else begin
                valid_d = 1'b0;
            end
            state_d = (cnt_d >= FIRST_WIN) ? RUN : FILL;
        end else if (bus.m_ready) begin
            valid_d = 1'b0;
        end
    end

    // State register; the shift register is deliberately kept across segments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            win_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = valid_q;
    assign bus.m_win   = win_q;
    assign bus.m_idx   = idx_q;
    assign bus.m_last  = last_q;

endmodule

// File: tb/tb_conv1_window_feeder.sv
// Self-checking bench for conv1_window_feeder: a table of directed vectors,
// hand-written sequences for segment wrap, backpressure, flush and async reset,
// and a negedge scoreboard that predicts every window from the sample stream.
module tb_conv1_window_feeder;
    import conv1_window_feeder_pkg::*;

    localparam int DW      = DEF_DW;
    localparam int K       = DEF_K;
    localparam int SEG_LEN = DEF_SEG_LEN;
    localparam int NV      = 15;

    typedef struct {
        sample_t data;
        logic    exp_valid;
        int      exp_idx;
        logic    check_win;
        window_t exp_win;
    } vec_t;

    typedef struct {
        window_t win;
        int      idx;
        logic    last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int nchecks = 0;
    int npass   = 0;

    conv1_window_feeder_if #(.DW(DW), .K(K), .SEG_LEN(SEG_LEN)) bus ();

    conv1_window_feeder #(.DW(DW), .K(K), .SEG_LEN(SEG_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nchecks++;
        if (actual === expected) npass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Offer one sample for exactly one clock edge, then look at the result just after the edge.
    task automatic apply_stimulus(input sample_t data);
        bus.s_valid = 1'b1;
        bus.s_data  = data;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    // Scoreboard model: segment position, pending-window flag and the last K accepted samples.
    int      pos;
    bit      pend;
    sample_t recent[$];
    exp_t    sb[$];

    // Compare the DUT against the model between edges, then advance the model to the next edge.
    always @(negedge clk or negedge rst) begin : monitor
        logic    exp_ready;
        exp_t    e;
        window_t w;
        if (!rst) begin
            pos  = 0;
            pend = 1'b0;
            recent.delete();
            sb.delete();
        end else begin
            exp_ready = !bus.flush && (!pend || bus.m_ready);
            check_output("s_ready", bus.s_ready, exp_ready);
            check_output("m_valid", bus.m_valid, pend);
            if (bus.m_valid) begin
                if (sb.size() == 0) begin
                    check_output("sb_size", sb.size(), 1);
                end else begin
                    e = sb[0];
                    check_output("sb_win", bus.m_win, e.win);
                    check_output("sb_idx", bus.m_idx, e.idx);
                    check_output("sb_last", bus.m_last, e.last);
                end
            end
            if (bus.flush) begin
                pos  = 0;
                pend = 1'b0;
                sb.delete();
            end else begin
                if (pend && bus.m_ready) begin
                    pend = 1'b0;
                    if (sb.size() > 0) void'(sb.pop_front());
                end
                if (bus.s_valid && exp_ready) begin
                    recent.push_back(bus.s_data);
                    if (recent.size() > K) void'(recent.pop_front());
                    if (pos >= K - 1) begin
                        for (int j = 0; j < K; j++) w[j] = recent[j];
                        e.win  = w;
                        e.idx  = pos - (K - 1);
                        e.last = (pos == SEG_LEN - 1);
                        sb.push_back(e);
                        pend = 1'b1;
                    end
                    pos = (pos == SEG_LEN - 1) ? 0 : pos + 1;
                end
            end
        end
    end

    vec_t vecs[NV];

    // Directed test sequence.
    initial begin : stim
        window_t saved_win;
        int nwin, nlast, last_idx, bad_seq, extra;
        sample_t edge_vals[5];

        edge_vals[0] = sample_t'(-128);
        edge_vals[1] = sample_t'(127);
        edge_vals[2] = sample_t'(-1);
        edge_vals[3] = sample_t'(0);
        edge_vals[4] = sample_t'(1);

        for (int i = 0; i < NV; i++) begin
            vecs[i].data      = (i < 10) ? sample_t'(i + 1) : edge_vals[i - 10];
            vecs[i].exp_valid = (i >= K - 1);
            vecs[i].exp_idx   = i - (K - 1);
            vecs[i].check_win = (i == 4) || (i == 9) || (i == 14);
            for (int j = 0; j < K; j++) begin
                if (i == 4)       vecs[i].exp_win[j] = sample_t'(j + 1);
                else if (i == 9) vecs[i].exp_win[j] = sample_t'(j + 6);
                else              vecs[i].exp_win[j] = edge_vals[j];
            end
        end

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b1;

        // Reset values.
        #1 rst = 1'b0;
        #2;
        check_output("rst_m_valid", bus.m_valid, 1'b0);
        check_output("rst_m_last", bus.m_last, 1'b0);
        check_output("rst_m_idx", bus.m_idx, 0);
        check_output("rst_m_win", bus.m_win, 0);
        #9 rst = 1'b1;
        #1;
        check_output("rst_s_ready", bus.s_ready, 1'b1);
        @(posedge clk);
        #1;

        // Table: samples 1..10 then the signed extremes.
        for (int i = 0; i < NV; i++) begin
            apply_stimulus(vecs[i].data);
            check_output("tbl_valid", bus.m_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check_output("tbl_idx", bus.m_idx, vecs[i].exp_idx);
            if (vecs[i].check_win) check_output("tbl_win", bus.m_win, vecs[i].exp_win);
        end
        check_output("win0_min", bus.m_win[0], 8'h80);
        check_output("win1_max", bus.m_win[1], 8'h7F);

        // Async reset pulse in the middle of a cycle while in RUN.
        #1 rst = 1'b0;
        #1;
        check_output("arst_m_valid", bus.m_valid, 1'b0);
        check_output("arst_m_last", bus.m_last, 1'b0);
        check_output("arst_m_idx", bus.m_idx, 0);
        check_output("arst_m_win", bus.m_win, 0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // One full segment, then the first window of the next segment.
        nwin = 0; nlast = 0; last_idx = -1; bad_seq = 0; extra = 0;
        for (int i = 0; i < SEG_LEN; i++) begin
            apply_stimulus(sample_t'(i % 128));
            if (bus.m_valid) begin
                if (int'(bus.m_idx) != nwin) bad_seq++;
                if (bus.m_last) begin
                    nlast++;
                    last_idx = int'(bus.m_idx);
                end
                nwin++;
            end
        end
        check_output("seg_windows", nwin, SEG_LEN - K + 1);
        check_output("seg_last_count", nlast, 1);
        check_output("seg_last_idx", last_idx, SEG_LEN - K);
        check_output("seg_idx_order", bad_seq, 0);
        for (int i = 0; i < K - 1; i++) begin
            apply_stimulus(sample_t'(i + 20));
            if (bus.m_valid) extra++;
        end
        check_output("wrap_fill_windows", extra, 0);
        apply_stimulus(sample_t'(24));
        check_output("wrap_valid", bus.m_valid, 1'b1);
        check_output("wrap_idx", bus.m_idx, 0);
        check_output("wrap_oldest", bus.m_win[0], 8'd20);

        // Backpressure: three stalled cycles, then accept and consume together.
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = sample_t'(77);
        saved_win   = bus.m_win;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_output("stall_s_ready", bus.s_ready, 1'b0);
            @(posedge clk);
            #1;
            check_output("stall_win", bus.m_win, saved_win);
            check_output("stall_valid", bus.m_valid, 1'b1);
        end
        bus.m_ready = 1'b1;
        #1;
        check_output("resume_s_ready", bus.s_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        check_output("resume_idx", bus.m_idx, 1);
        check_output("resume_newest", bus.m_win[K-1], 8'd77);

        // Flush at cnt = 50 with a window pending.
        for (int i = 0; i < 44; i++) apply_stimulus(sample_t'(-i));
        check_output("pre_flush_idx", bus.m_idx, 45);
        check_output("pre_flush_valid", bus.m_valid, 1'b1);
        bus.flush   = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = sample_t'(99);
        #1;
        check_output("flush_s_ready", bus.s_ready, 1'b0);
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.s_valid = 1'b0;
        check_output("flush_m_valid", bus.m_valid, 1'b0);
        check_output("flush_m_last", bus.m_last, 1'b0);
        extra = 0;
        for (int i = 0; i < K - 1; i++) begin
            apply_stimulus(sample_t'(i + 10));
            if (bus.m_valid) extra++;
        end
        check_output("flush_fill_windows", extra, 0);
        apply_stimulus(sample_t'(14));
        check_output("flush_restart_valid", bus.m_valid, 1'b1);
        check_output("flush_restart_idx", bus.m_idx, 0);
        check_output("flush_restart_oldest", bus.m_win[0], 8'd10);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
